w_value_ram_reader: RTL and testbench

//  Read-side sequencer for the w-value RAM. On start, streams COUNT consecutive

---
 rtl/w_value_ram_reader.sv | 158 +++++++++++++++
 tb/tb_w_value_ram_reader.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/w_value_ram_reader.sv
// w_value_ram_reader
//   Read-side sequencer for the w-value RAM. On an accepted start it streams
//   `count` consecutive words beginning at `base_addr` to a valid/ready
//   consumer. It absorbs the RAM's one-cycle registered-read latency with a
//   one-bit in-flight tracker and a 2-entry output FIFO.
//   Optional feature macro: W_READER_CHECKSUM_EN adds the `checksum` output.
module w_value_ram_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   count,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    output logic                  ram_en,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
`ifdef W_READER_CHECKSUM_EN
   ,output logic [DATA_WIDTH-1:0] checksum
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;

    // Sequencer state
    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_remaining;
    logic                  r_inflight;
    logic                  r_done;

    // Output FIFO
    logic [DATA_WIDTH-1:0] r_mem [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_occ;

    // Combinational handshake / issue decisions
    logic       w_pop;
    logic       w_push;
    logic [1:0] w_occ_after_pop;
    logic [2:0] w_slots_used;
    logic       w_issue;
    logic [1:0] w_occ_next;

    // Issue decision: occupancy is counted after this cycle's pop, so a
    // word leaving the buffer frees its slot in the same cycle. That is what
    // sustains one word per cycle with out_ready held high.
    always_comb begin
        w_pop           = (r_occ != 2'd0) && out_ready;
        w_push          = r_inflight;
        w_occ_after_pop = r_occ - {1'b0, w_pop};
        w_slots_used    = {1'b0, w_occ_after_pop} + {2'b00, r_inflight};
        w_issue         = (r_state == S_RUN) && (w_slots_used < 3'd2);
        w_occ_next      = w_occ_after_pop + {1'b0, w_push};
    end

    assign ram_en    = w_issue;
    assign ram_raddr = r_addr;
    assign out_valid = (r_occ != 2'd0);
    assign out_data  = r_mem[r_rd_ptr];
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;

    // Burst sequencing: accept start, advance address per issue, drain, pulse done
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_inflight  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_inflight <= w_issue;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (count != '0) begin
                            r_state     <= S_RUN;
                            r_addr      <= base_addr;
                            r_remaining <= count;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (w_issue) begin
                        r_addr      <= r_addr + ADDR_ONE;
                        r_remaining <= r_remaining - CNT_ONE;
                        if (r_remaining == CNT_ONE) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // Nothing is issued here, so an empty next-state buffer
                    // also means nothing is left in flight.
                    if (w_occ_next == 2'd0) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Output FIFO: capture RAM data one cycle after issue, release on handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= ram_q;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_occ <= w_occ_next;
        end
    end

`ifdef W_READER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_checksum;

    // Running modular sum of accepted words; restarts on every accepted start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_checksum <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_checksum <= '0;
        end else if (w_pop) begin
            r_checksum <= r_checksum + out_data;
        end
    end

    assign checksum = r_checksum;
`endif

endmodule

// File: tb/tb_w_value_ram_reader.sv
// Self-checking bench for w_value_ram_reader: a RAM model with one-cycle
// registered read, a scoreboard of expected addresses/words filled when a
// burst is issued, and a negedge monitor that pops and compares.
module tb_w_value_ram_reader;
    localparam int DW    = 8;
    localparam int AW    = 7;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   count;
    logic [DW-1:0] ram_q;
    logic [AW-1:0] ram_raddr;
    logic          ram_en;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;
`ifdef W_READER_CHECKSUM_EN
    logic [DW-1:0] checksum;
    logic [DW-1:0] exp_sum = '0;
`endif

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] exp_addr [$];
    logic [DW-1:0] exp_data [$];
    int            pop_cycs [$];
    int            cyc        = 0;
    int            done_seen  = 0;
    int            done_cyc   = 0;
    int            n_cmp      = 0;
    int            n_err      = 0;
    int            ready_mode = 0;
    logic          stall_pending = 1'b0;
    logic [DW-1:0] stall_data    = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    w_value_ram_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .ram_q     (ram_q),
        .ram_raddr (ram_raddr),
        .ram_en    (ram_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
`ifdef W_READER_CHECKSUM_EN
       ,.checksum  (checksum)
`endif
    );

    // RAM model: address latched with ram_en, data visible the following cycle
    always @(posedge clk) if (ram_en) ram_q <= mem[ram_raddr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: address order, word order, stall stability, done placement
    always @(negedge clk) begin
        if (reset) begin
            stall_pending = 1'b0;
        end else begin
            if (ram_en) begin
                if (exp_addr.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL spurious ram_en: got addr %0h, expected no read", ram_raddr);
                end else begin
                    chk("ram_raddr", 32'(ram_raddr), 32'(exp_addr.pop_front()));
                end
            end
            if (stall_pending) begin
                chk("stall out_valid", 32'(out_valid), 32'd1);
                chk("stall out_data", 32'(out_data), 32'(stall_data));
            end
            stall_pending = out_valid && !out_ready;
            stall_data    = out_data;
            if (out_valid && out_ready) begin
                pop_cycs.push_back(cyc);
                if (exp_data.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL spurious word: got %0h, expected none", out_data);
                end else begin
                    chk("out_data", 32'(out_data), 32'(exp_data.pop_front()));
                end
            end
            if (done) begin
                done_seen++;
                done_cyc = cyc;
                chk("done before all words", 32'(exp_data.size()), 32'd0);
            end
        end
    end

    // Issue a start pulse; expectations are queued from the reference RAM contents
    task automatic burst(input logic [AW-1:0] b, input int n, output int s);
        @(posedge clk); #1;
        pop_cycs.delete();
`ifdef W_READER_CHECKSUM_EN
        exp_sum = '0;
`endif
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(AW'(b + AW'(i)));
            exp_data.push_back(mem[AW'(b + AW'(i))]);
`ifdef W_READER_CHECKSUM_EN
            exp_sum = exp_sum + mem[AW'(b + AW'(i))];
`endif
        end
        base_addr = b;
        count     = (AW+1)'(n);
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        s     = cyc;
    endtask

    task automatic run_until_done(input int budget);
        int d0;
        d0 = done_seen;
        for (int k = 0; k < budget; k++) begin
            if (done_seen != d0) break;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (k % 2 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            @(posedge clk); #1;
        end
        if (done_seen == d0) begin
            n_cmp++; n_err++;
            $display("FAIL done timeout: got no done, expected one within %0d cycles", budget);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("busy after done", 32'(busy), 32'd0);
        chk("leftover words", 32'(exp_data.size()), 32'd0);
        chk("leftover addrs", 32'(exp_addr.size()), 32'd0);
`ifdef W_READER_CHECKSUM_EN
        chk("checksum", 32'(checksum), 32'(exp_sum));
`endif
    endtask

    task automatic chk_reset_outputs();
        chk("rst ram_raddr", 32'(ram_raddr), 32'd0);
        chk("rst ram_en", 32'(ram_en), 32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_data", 32'(out_data), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
    endtask

    initial begin
        int s;
        int d0;
        int n;
        reset     = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        base_addr = '0;
        count     = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs();
        reset = 1'b0;

        // Basic burst: latency, back-to-back words, done one cycle after last
        ready_mode = 0;
        out_ready  = 1'b1;
        burst(7'h10, 4, s);
        @(negedge clk);
        chk("busy after start", 32'(busy), 32'd1);
        run_until_done(40);
        chk("word count x10", 32'(pop_cycs.size()), 32'd4);
        if (pop_cycs.size() == 4) begin
            chk("first word latency", 32'(pop_cycs[0] - s), 32'd2);
            for (int i = 1; i < 4; i++)
                chk("back-to-back", 32'(pop_cycs[i] - pop_cycs[i-1]), 32'd1);
            chk("done delay", 32'(done_cyc - pop_cycs[3]), 32'd1);
        end

        // Address wrap
        burst(7'h7E, 4, s);
        run_until_done(40);

        // Full-depth burst with toggling ready
        ready_mode = 1;
        burst(7'h00, 128, s);
        run_until_done(600);
        chk("word count 128", 32'(pop_cycs.size()), 32'd128);

        // count == 0: no busy, single done pulse next cycle
        ready_mode = 0;
        d0 = done_seen;
        burst(7'h22, 0, s);
        chk("busy on zero count", 32'(busy), 32'd0);
        @(negedge clk);
        chk("zero-count done", 32'(done), 32'd1);
        @(negedge clk);
        chk("zero-count done width", 32'(done), 32'd0);
        chk("zero-count done pulses", 32'(done_seen - d0), 32'd1);

        // start while busy is ignored
        d0 = done_seen;
        burst(7'h20, 6, s);
        base_addr = 7'h55;
        count     = 8'd9;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        run_until_done(60);
        repeat (5) @(negedge clk);
        chk("ignored start dones", 32'(done_seen - d0), 32'd1);

        // Asynchronous reset mid-burst
        burst(7'h30, 8, s);
        for (int k = 0; k < 40 && pop_cycs.size() < 2; k++) begin
            @(negedge clk); #1;
        end
        if (pop_cycs.size() < 2) begin
            n_cmp++; n_err++;
            $display("FAIL mid-burst wait: got %0d words, expected 2", pop_cycs.size());
        end
        #1 reset = 1'b1;
        #1;
        chk_reset_outputs();
        exp_addr.delete();
        exp_data.delete();
        d0 = done_seen;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("no done after reset", 32'(done_seen - d0), 32'd0);
        ready_mode = 2;
        burst(7'h40, 5, s);
        run_until_done(80);

`ifdef W_READER_CHECKSUM_EN
        ready_mode = 0;
        burst(7'h7F, 2, s);
        run_until_done(40);
        chk("checksum 7F+00", 32'(checksum), 32'h7F);
`endif

        // Randomized bursts against fresh RAM contents
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
            ready_mode = int'($urandom_range(0, 2));
            n = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 128));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            burst(AW'($urandom), n, s);
            run_until_done(4 * n + 40);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish before 500000 ns");
        $fatal(1);
    end

endmodule
